// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared op encoding and signed-overflow helper for adder datapaths
//
// Contents:
//   OP_ADD / OP_SUB : encoding of the sub_i mode bit
//   signed_ovf()    : two's-complement overflow from operand and result sign bits
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Overflow happens when both addends share a sign and the result does not.
   // b_eff_msb is the sign of the operand actually added (already inverted for subtract).
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_eff_msb,
                                       input logic sum_msb);
      return (a_msb == b_eff_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - valid/ready request and response bundle of the pipelined adder
//
// Request side  : valid_i, ready_o, a_i, b_i, sub_i, cin_i
// Response side : valid_o, ready_i, sum_o, cout_o, ovf_o
// master drives requests and consumes responses; slave is the adder itself.
interface adder_pipe_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             sub_i;
   logic             cin_i;

   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] sum_o;
   logic             cout_o;
   logic             ovf_o;

   modport master (
      output valid_i, a_i, b_i, sub_i, cin_i, ready_i,
      input  ready_o, valid_o, sum_o, cout_o, ovf_o
   );

   modport slave (
      input  valid_i, a_i, b_i, sub_i, cin_i, ready_i,
      output ready_o, valid_o, sum_o, cout_o, ovf_o
   );
endinterface

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - one pipeline stage: resolves SEG result bits and registers the carry
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   valid_i                upstream stage (or request) holds a transaction
//   res_i                  result bits resolved so far (segments below IDX)
//   a_i, b_i               operand A and effective operand B (inverted for subtract)
//   carry_i                carry into segment IDX
//   next_load_i            downstream stage / output is taking data this cycle
//   load_o                 this stage takes data this cycle
//   valid_o, res_o, a_o,
//   b_o, carry_o, ovf_o    registered stage contents
module adder_seg
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 16,
   parameter int IDX   = 0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] res_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             next_load_i,
   output logic             load_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] res_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             carry_o,
   output logic             ovf_o
);

   localparam int LO = IDX * SEG;

   logic             valid_q;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [SEG:0]     seg_sum;

   // Segment adder: one extra bit catches the carry into the next segment.
   always_comb begin
      seg_sum = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]} + {{SEG{1'b0}}, carry_i};
      res_d            = res_i;
      res_d[LO +: SEG] = seg_sum[SEG-1:0];
      carry_d          = seg_sum[SEG];
      // Only meaningful in the last stage, where res_d holds the complete sum.
      ovf_d            = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], res_d[WIDTH-1]);
   end

   // An empty stage always accepts, so bubbles collapse even under a stalled output.
   assign load_o = !valid_q || next_load_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         res_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load_o) begin
         valid_q <= valid_i;
         // Data only moves with a real transaction; bubbles leave the last value in place.
         if (valid_i) begin
            res_q   <= res_d;
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign res_o   = res_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign carry_o = carry_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined WIDTH-bit adder/subtractor with valid/ready handshakes
//
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset; empties the pipe
//   bus      adder_pipe_if.slave: request (valid_i/ready_o/a_i/b_i/sub_i/cin_i) and
//            response (valid_o/ready_i/sum_o/cout_o/ovf_o)
// Parameters:
//   WIDTH    operand/result width
//   STAGES   pipeline depth; each stage resolves WIDTH/STAGES bits, low segment first
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   adder_pipe_if.slave bus
);

   localparam int SEG = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("adder_pipe: STAGES must be in 1..WIDTH and divide WIDTH evenly");
   end

   // Index k is the input of stage k; index STAGES is the pipe output.
   logic [STAGES:0]  valid_c;
   logic [STAGES:0]  load_c;
   logic [STAGES:0]  carry_c;
   logic [WIDTH-1:0] res_c [STAGES+1];
   logic [WIDTH-1:0] a_c   [STAGES+1];
   logic [WIDTH-1:0] b_c   [STAGES+1];
   logic [STAGES-1:0] ovf_v;
   logic             unused_tail;

   // Subtract is A + ~B + 1: invert B once here and force the first carry.
   assign valid_c[0] = bus.valid_i;
   assign res_c[0]   = '0;
   assign a_c[0]     = bus.a_i;
   assign b_c[0]     = (bus.sub_i == OP_SUB) ? ~bus.b_i : bus.b_i;
   assign carry_c[0] = (bus.sub_i == OP_SUB) ? 1'b1 : bus.cin_i;

   assign load_c[STAGES] = bus.ready_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_seg #(
         .WIDTH (WIDTH),
         .SEG   (SEG),
         .IDX   (k)
      ) u_seg (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .valid_i     (valid_c[k]),
         .res_i       (res_c[k]),
         .a_i         (a_c[k]),
         .b_i         (b_c[k]),
         .carry_i     (carry_c[k]),
         .next_load_i (load_c[k+1]),
         .load_o      (load_c[k]),
         .valid_o     (valid_c[k+1]),
         .res_o       (res_c[k+1]),
         .a_o         (a_c[k+1]),
         .b_o         (b_c[k+1]),
         .carry_o     (carry_c[k+1]),
         .ovf_o       (ovf_v[k])
      );
   end

   // Reset forces ready high: the pipe is empty on the next edge regardless of load state.
   assign bus.ready_o = load_c[0] | reset_i;
   assign bus.valid_o = valid_c[STAGES];
   assign bus.sum_o   = res_c[STAGES];
   assign bus.cout_o  = carry_c[STAGES];
   assign bus.ovf_o   = ovf_v[STAGES-1];

   // The last stage's operand copies and the early stages' overflow bits have no consumer.
   assign unused_tail = ^{a_c[STAGES], b_c[STAGES], ovf_v};

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe across four WIDTH/STAGES configurations
module tb_adder_pipe;
   import adder_pkg::*;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic        cin;
   } stim_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: exact unsigned and signed arithmetic on wide integers, then reduced to w bits.
   function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input logic cin,
                                     output logic [63:0] sum, output logic cout, output logic ovf);
      logic [127:0]        full, ua, ub, ur;
      logic signed [63:0]  ta, tb;
      logic signed [127:0] sa, sb, sr, lim;
      full = 128'd1 << w;
      ua   = {64'd0, a} & (full - 128'd1);
      ub   = {64'd0, b} & (full - 128'd1);
      if (sub) ur = ua + full - ub;
      else     ur = ua + ub + {127'd0, cin};
      sum  = ur[63:0] & 64'((full - 128'd1));
      cout = (ur >= full);
      ta   = $signed(a << (64 - w)) >>> (64 - w);
      tb   = $signed(b << (64 - w)) >>> (64 - w);
      sa   = ta;
      sb   = tb;
      if (sub) sr = sa - sb;
      else     sr = sa + sb + $signed({127'd0, cin});
      lim  = 128'sd1 <<< (w - 1);
      ovf  = (sr >= lim) || (sr < -lim);
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
      localparam int S = (g == 0) ? 2  : (g == 1) ? 1 : (g == 2) ? 4  : 8;

      adder_pipe_if #(.WIDTH(W)) bus ();
      logic  rst = 1'b1;
      bit    chk_lat = 1'b1;
      bit    done_b = 1'b0;
      exp_t  q[$];
      stim_t stim[$];

      adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
         .clk_i   (clk),
         .reset_i (rst),
         .bus     (bus.slave)
      );

      // Feeder: presents queued operands one after another, holding each until accepted.
      initial begin
         stim_t s;
         bit    ok;
         bus.valid_i = 1'b0;
         bus.a_i     = '0;
         bus.b_i     = '0;
         bus.sub_i   = 1'b0;
         bus.cin_i   = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            if (stim.size() == 0) begin
               bus.valid_i = 1'b0;
            end else begin
               s           = stim.pop_front();
               bus.valid_i = 1'b1;
               bus.a_i     = W'(s.a);
               bus.b_i     = W'(s.b);
               bus.sub_i   = s.sub;
               bus.cin_i   = s.cin;
               ok          = 1'b0;
               for (int c = 0; c < 100 && !ok; c++) begin
                  @(negedge clk);
                  ok = bus.ready_o && !rst;
               end
               check($sformatf("accept W%0d S%0d", W, S), 64'(ok), 64'd1);
            end
         end
      end

      // Scoreboard: checks ready_o every cycle and each presented result against the model.
      always @(negedge clk) begin
         exp_t e;
         logic exp_rdy;
         exp_rdy = rst || !(q.size() == S && !bus.ready_i);
         check($sformatf("ready_o W%0d S%0d", W, S), 64'(bus.ready_o), 64'(exp_rdy));
         if (rst) begin
            q.delete();
         end else begin
            if (bus.valid_o !== 1'b0) begin
               if (q.size() == 0) begin
                  check($sformatf("spurious valid_o W%0d S%0d", W, S), 64'(bus.valid_o), 64'd0);
               end else begin
                  e = q[0];
                  check($sformatf("sum_o W%0d S%0d", W, S),  64'(bus.sum_o),  e.sum);
                  check($sformatf("cout_o W%0d S%0d", W, S), 64'(bus.cout_o), 64'(e.cout));
                  check($sformatf("ovf_o W%0d S%0d", W, S),  64'(bus.ovf_o),  64'(e.ovf));
                  if (bus.ready_i) begin
                     if (chk_lat)
                        check($sformatf("latency W%0d S%0d", W, S), 64'(cyc - e.acc), 64'(S));
                     void'(q.pop_front());
                  end
               end
            end
            if (bus.valid_i && bus.ready_o) begin
               ref_model(W, 64'(bus.a_i), 64'(bus.b_i), bus.sub_i, bus.cin_i, e.sum, e.cout, e.ovf);
               e.acc = cyc;
               q.push_back(e);
            end
         end
      end

      if (g == 0) begin : g_main
         bit          bp_on     = 1'b0;
         logic        rdy_force = 1'b1;
         bit          bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         logic [31:0] da  [9] = '{32'h0, 32'h1001, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                  32'h0000FFFF, 32'h5, 32'h7, 32'h80000000};
         logic [31:0] db  [9] = '{32'h1, 32'hA00A, 32'hFFFF, 32'h1, 32'h1,
                                  32'h1, 32'h7, 32'h5, 32'h1};
         logic        ds  [9] = '{OP_ADD, OP_ADD, OP_ADD, OP_ADD, OP_ADD,
                                  OP_ADD, OP_SUB, OP_SUB, OP_SUB};
         logic        dc  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         logic [31:0] de  [9] = '{32'h1, 32'hB00B, 32'h10000, 32'h0, 32'h80000000,
                                  32'h00010001, 32'hFFFFFFFE, 32'h2, 32'h7FFFFFFF};
         logic        dco [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
         logic        dov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

         initial begin
            int k = 0;
            bus.ready_i = 1'b1;
            forever begin
               @(posedge clk);
               #1;
               if (bp_on) begin
                  bus.ready_i = bp_pat[k % 6];
                  k++;
               end else begin
                  bus.ready_i = rdy_force;
               end
            end
         end

         initial begin
            stim_t       st;
            logic [63:0] s;
            logic        co, ov;
            bit          idle;

            rst = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            rst = 1'b0;
            @(negedge clk);
            check("reset valid_o", 64'(bus.valid_o), 64'd0);
            check("reset sum_o",   64'(bus.sum_o),   64'd0);
            check("reset ready_o", 64'(bus.ready_o), 64'd1);

            for (int i = 0; i < 9; i++) begin
               ref_model(32, 64'(da[i]), 64'(db[i]), ds[i], dc[i], s, co, ov);
               check($sformatf("model sum vec%0d", i),  s,       64'(de[i]));
               check($sformatf("model cout vec%0d", i), 64'(co), 64'(dco[i]));
               check($sformatf("model ovf vec%0d", i),  64'(ov), 64'(dov[i]));
            end

            // Directed add/sub vectors, back to back with the output always ready.
            for (int i = 0; i < 9; i++) begin
               st.a = 64'(da[i]); st.b = 64'(db[i]); st.sub = ds[i]; st.cin = dc[i];
               stim.push_back(st);
            end
            idle = 1'b0;
            for (int c = 0; c < 200 && !idle; c++) begin
               @(posedge clk);
               #2;
               idle = (stim.size() == 0) && (q.size() == 0) && !bus.valid_i;
            end
            check("drain directed", 64'(idle), 64'd1);

            // Backpressure: output ready toggles 1,0,0,1,0,1...
            chk_lat = 1'b0;
            bp_on   = 1'b1;
            for (int i = 0; i < 6; i++) begin
               st.a   = 64'($urandom);
               st.b   = 64'($urandom);
               st.sub = 1'($urandom_range(0, 1));
               st.cin = 1'($urandom_range(0, 1));
               stim.push_back(st);
            end
            idle = 1'b0;
            for (int c = 0; c < 300 && !idle; c++) begin
               @(posedge clk);
               #2;
               idle = (stim.size() == 0) && (q.size() == 0) && !bus.valid_i;
            end
            check("drain backpressure", 64'(idle), 64'd1);
            bp_on = 1'b0;

            // Mid-stream reset with two transactions held inside a stalled pipe.
            rdy_force = 1'b0;
            @(posedge clk);
            #2;
            st.a = 64'h1001; st.b = 64'hA00A; st.sub = OP_ADD; st.cin = 1'b0;
            stim.push_back(st);
            st.a = 64'h7; st.b = 64'h5; st.sub = OP_SUB;
            stim.push_back(st);
            idle = 1'b0;
            for (int c = 0; c < 50 && !idle; c++) begin
               @(posedge clk);
               #2;
               idle = (stim.size() == 0) && !bus.valid_i;
            end
            check("two in flight", 64'(q.size()), 64'd2);
            rst = 1'b1;
            @(posedge clk);
            #2;
            rst = 1'b0;
            @(negedge clk);
            check("post-flush valid_o", 64'(bus.valid_o), 64'd0);
            check("post-flush sum_o",   64'(bus.sum_o),   64'd0);
            check("post-flush ready_o", 64'(bus.ready_o), 64'd1);
            rdy_force = 1'b1;
            repeat (10) @(posedge clk);

            // Recovery after the flush.
            #2;
            chk_lat = 1'b1;
            for (int i = 3; i < 6; i++) begin
               st.a = 64'(da[i]); st.b = 64'(db[i]); st.sub = ds[i]; st.cin = dc[i];
               stim.push_back(st);
            end
            idle = 1'b0;
            for (int c = 0; c < 200 && !idle; c++) begin
               @(posedge clk);
               #2;
               idle = (stim.size() == 0) && (q.size() == 0) && !bus.valid_i;
            end
            check("drain recovery", 64'(idle), 64'd1);
            done_b = 1'b1;
         end
      end else begin : g_sweep
         initial begin
            stim_t st;
            bit    idle;
            bus.ready_i = 1'b1;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            rst = 1'b0;
            for (int i = 0; i < 40; i++) begin
               st.a   = {$urandom, $urandom};
               st.b   = {$urandom, $urandom};
               st.sub = 1'($urandom_range(0, 1));
               st.cin = 1'($urandom_range(0, 1));
               stim.push_back(st);
            end
            idle = 1'b0;
            for (int c = 0; c < 400 && !idle; c++) begin
               @(posedge clk);
               #2;
               idle = (stim.size() == 0) && (q.size() == 0) && !bus.valid_i;
            end
            check($sformatf("drain sweep W%0d S%0d", W, S), 64'(idle), 64'd1);
            done_b = 1'b1;
         end
      end
   end

   initial begin
      bit all_done = 1'b0;
      for (int c = 0; c < 20000 && !all_done; c++) begin
         @(posedge clk);
         all_done = g_cfg[0].done_b && g_cfg[1].done_b && g_cfg[2].done_b && g_cfg[3].done_b;
      end
      check("all configurations finished", 64'(all_done), 64'd1);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined two-operand adder/subtractor that generalises the 32-bit combinational adder.
- WIDTH-bit operands are split into STAGES equal segments. Each pipeline stage resolves one segment, low segment first, and registers the carry into the next stage.
- A valid/ready handshake on both sides lets it sit inside streaming datapaths (ALU back-ends, accumulators) with full backpressure and one transaction per cycle of throughput.

Parameters:
WIDTH, 32, operand/result width in bits; WIDTH % STAGES == 0 is required (elaboration-time assertion).
STAGES, 2, pipeline depth and carry-segment count, 1..WIDTH; SEG = WIDTH/STAGES bits resolved per stage.

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
reset_i  in  1  synchronous, active-high reset.
valid_i  in  1  input transaction valid.
ready_o  out  1  block can accept an input this cycle.
a_i  in  WIDTH  operand A.
b_i  in  WIDTH  operand B.
sub_i  in  1  0 = A+B+cin_i; 1 = A-B (A + ~B + 1, cin_i ignored).
cin_i  in  1  carry-in, add mode only.
valid_o  out  1  result valid.
ready_i  in  1  downstream accepts the result.
sum_o  out  WIDTH  result, modulo 2^WIDTH.
cout_o  out  1  carry out of the MSB; in subtract mode 1 means no borrow (A >= B unsigned).
ovf_o  out  1  two's-complement signed overflow.

Behaviour:
- Transfers: input transfer when valid_i && ready_o; output transfer when valid_o && ready_i.
- Stages and reset: STAGES register stages, each with a valid bit. On reset_i, every valid bit, sum_o, cout_o and ovf_o go to 0 on the next edge. ready_o is combinational and equals 1 during and after reset (the pipe is empty).
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and of B_eff = sub ? ~B : B, plus the carry from stage k-1. Stage 0 carry = sub ? 1 : cin_i.
  - Registers: the resolved low result bits, the upper unresolved operand bits, the carry, and the sign bits needed for overflow.
- Latency: exactly STAGES cycles from input transfer to valid_o with no backpressure. STAGES = 1 gives a single registered adder.
- Throughput: one result per cycle while ready_i = 1.
- Backpressure: stage k may load when its valid bit is 0 or stage k+1 (or the output, for the last stage) is loading/accepting. ready_o = stage-0 load enable.
  - Bubbles collapse: an empty stage always accepts, even while the output is stalled.
  - A stalled stage holds every register unchanged.
- Output stability: while valid_o = 1 and ready_i = 0, sum_o/cout_o/ovf_o are stable.
- Overflow: ovf_o = (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]), computed in the final stage from the registered sign bits.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with a full pipe: all stages advance and no data is lost or duplicated.
  - reset_i takes priority over any handshake.
- Reset mid-operation: all in-flight transactions are discarded and valid_o = 0 from the next cycle.
- Unknown values: no X may propagate on sum_o when valid_o = 0. Outputs hold their last value or 0 after reset.

Decomposition:
- Shared package adder_pkg holds:
  - the op encoding localparams (OP_ADD = 1'b0, OP_SUB = 1'b1);
  - a parametrised helper function for the signed-overflow expression, reused by ALU blocks.
- Sub-module adder_seg: one pipeline stage with its segment adder, stage registers, valid bit and load-enable logic. adder_pipe instantiates STAGES copies in a generate loop and ties off the ends.

Test Plan:
1. WIDTH=32, STAGES=2, add, ready_i=1. Inputs 0+1, 0x1001+0xA00A, 0x1+0xFFFF back-to-back -> sum_o 0x1, 0xB00B, 0x10000 on consecutive cycles, first result 2 cycles after the first accept; cout_o=0, ovf_o=0.
2. Carry and overflow boundaries:
   - 0xFFFFFFFF+0x1 -> sum 0, cout 1, ovf 0.
   - 0x7FFFFFFF+0x1 -> 0x80000000, cout 0, ovf 1.
   - 0x0000FFFF+0x1, cin=1 -> 0x00010001 (carry crosses the segment boundary).
3. Subtract:
   - 5-7 -> 0xFFFFFFFE, cout 0.
   - 7-5 -> 0x2, cout 1.
   - 0x80000000-0x1 -> 0x7FFFFFFF, ovf 1.
4. Backpressure:
   - Stream 6 operands with ready_i toggling 1,0,0,1,0,1... -> all 6 results in order, none dropped or duplicated, outputs stable while stalled.
   - ready_o falls only when both stages are full and ready_i = 0.
5. Reset mid-stream: reset_i asserted for 1 cycle with 2 transactions in flight -> valid_o=0 and sum_o=0 the next cycle, ready_o=1, no stale result emerges afterwards.
6. Parameter sweep (WIDTH,STAGES) = (8,1), (16,4), (64,8), random operands/modes vs a reference model -> exact match, latency = STAGES.
